// File: rtl/io_pwr_seq_pkg.sv
// io_pwr_seq_pkg: shared types and constants for the IO pad-ring power sequencer.
//   io_pwr_state_t : sequencer FSM state encoding
//   BROWNOUT_W     : width of the optional brownout event counter
//   max_u          : elaboration-time max helper for sizing the shared counter
package io_pwr_seq_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD_RST = 2'd2,
        READY    = 2'd3
    } io_pwr_state_t;

    localparam int unsigned BROWNOUT_W = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/io_sync_ff.sv
// io_sync_ff: reset-to-0 flop chain bringing an asynchronous pad-ring status bit
// into the clk domain.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears the whole chain
//   d   : asynchronous input
//   q   : synchronised output, SYNC_STAGES flops after d
module io_sync_ff #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift chain; bit 0 is the metastability-exposed stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/io_pwr_seq.sv
// io_pwr_seq: power-up sequencer for the IO pad ring.
// Synchronises and debounces VDDIO-good, then drops pad isolation followed by the
// IO-domain reset. Any supply drop or software isolation request re-isolates at once.
//   CLK          : system clock
//   RST          : synchronous active-high reset
//   VDDIO_OK     : async supply-good from the ring detector
//   SW_ISO_REQ   : level request to hold pads isolated
//   PAD_ISO      : 1 = pads isolated
//   IO_RST       : active-high reset to IO-domain logic
//   IO_READY     : 1 = sequence complete, pads live
//   BROWNOUT_CNT : saturating count of supply-drop exits from READY
//                  (only when IO_PWR_SEQ_BROWNOUT_CNT_EN is defined)
module io_pwr_seq
    import io_pwr_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(max_u(DEBOUNCE_CYCLES, RST_HOLD_CYCLES)) + 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic VDDIO_OK,
    input  logic SW_ISO_REQ,
    output logic PAD_ISO,
    output logic IO_RST,
    output logic IO_READY
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
    ,
    output logic [BROWNOUT_W-1:0] BROWNOUT_CNT
`endif
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

    logic             ok_s;
    io_pwr_state_t    state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             iso_nxt, iorst_nxt, rdy_nxt;
    logic             abort;

    io_sync_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_vddio (
        .clk (CLK),
        .rst (RST),
        .d   (VDDIO_OK),
        .q   (ok_s)
    );

    // State, counter and decoded outputs; outputs are registered from the next state
    // so they change on the same edge as the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            PAD_ISO  <= 1'b1;
            IO_RST   <= 1'b1;
            IO_READY <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            PAD_ISO  <= iso_nxt;
            IO_RST   <= iorst_nxt;
            IO_READY <= rdy_nxt;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        abort     = (state_q != OFF) && (!ok_s || SW_ISO_REQ);

        case (state_q)
            OFF: begin
                cnt_nxt = '0;
                if (ok_s && !SW_ISO_REQ) begin
                    state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (cnt_q == DEB_LAST) begin
                    state_nxt = HOLD_RST;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            HOLD_RST: begin
                if (cnt_q == HOLD_LAST) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            READY: begin
                cnt_nxt = '0;
            end
            default: begin
                state_nxt = OFF;
                cnt_nxt   = '0;
            end
        endcase

        // Supply loss or software request beats any forward step; a debounce
        // glitch therefore restarts from zero via OFF.
        if (abort) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
        end

        iso_nxt   = (state_nxt == OFF) || (state_nxt == DEBOUNCE);
        iorst_nxt = (state_nxt != READY);
        rdy_nxt   = (state_nxt == READY);
    end

`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
    logic brownout_evt;

    // Only supply loss out of READY counts; software isolation is deliberate.
    assign brownout_evt = (state_q == READY) && !ok_s;

    // Saturating brownout counter, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BROWNOUT_CNT <= '0;
        end else if (brownout_evt && (BROWNOUT_CNT != {BROWNOUT_W{1'b1}})) begin
            BROWNOUT_CNT <= BROWNOUT_CNT + BROWNOUT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_io_pwr_seq.sv
// tb_io_pwr_seq: directed self-checking bench for io_pwr_seq with
// DEBOUNCE_CYCLES=8, RST_HOLD_CYCLES=4, SYNC_STAGES=2. Edge numbers below count
// rising CLK edges after the stimulus change; outputs are sampled 1 time unit after
// each edge. Brownout checks are active when IO_PWR_SEQ_BROWNOUT_CNT_EN is defined.
module tb_io_pwr_seq;
    import io_pwr_seq_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    logic VDDIO_OK;
    logic SW_ISO_REQ;
    logic PAD_ISO;
    logic IO_RST;
    logic IO_READY;
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
    logic [BROWNOUT_W-1:0] BROWNOUT_CNT;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic inv_en = 1'b0;
    logic prev_iso = 1'b1;
    logic prev_rst = 1'b1;

    io_pwr_seq #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .RST_HOLD_CYCLES (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .VDDIO_OK     (VDDIO_OK),
        .SW_ISO_REQ   (SW_ISO_REQ),
        .PAD_ISO      (PAD_ISO),
        .IO_RST       (IO_RST),
        .IO_READY     (IO_READY)
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
        ,
        .BROWNOUT_CNT (BROWNOUT_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic iso, input logic rst, input logic rdy);
        chk({tag, ".iso"}, 32'(PAD_ISO), 32'(iso));
        chk({tag, ".rst"}, 32'(IO_RST), 32'(rst));
        chk({tag, ".rdy"}, 32'(IO_READY), 32'(rdy));
    endtask

    // One clock edge, then the invariants that must hold on every cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (inv_en) begin
            chk("no_x", 32'($isunknown({PAD_ISO, IO_RST, IO_READY})), 32'(0));
            chk("rdy_implies_rst0", 32'(IO_READY & IO_RST), 32'(0));
            chk("iso_fall_order", 32'(!PAD_ISO && prev_iso && !prev_rst), 32'(0));
            chk("cnt_bound", 32'(dut.cnt_q < 4'd8), 32'(1));
        end
        prev_iso = PAD_ISO;
        prev_rst = IO_RST;
    endtask

    initial begin
        RST        = 1'b1;
        VDDIO_OK   = 1'b0;
        SW_ISO_REQ = 1'b0;
        repeat (3) tick();
        expect_out("reset", 1'b1, 1'b1, 1'b0);
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
        chk("reset.bo", 32'(BROWNOUT_CNT), 32'(0));
`endif
        inv_en = 1'b1;

        // 1: clean power-up, ISO falls at edge 11, READY at edge 15.
        RST      = 1'b0;
        VDDIO_OK = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            expect_out($sformatf("t1.e%0d", e), e < 11, e < 15, e >= 15);
        end

        // 2: one-cycle VDDIO_OK glitch mid-debounce restarts it; ISO falls at 17.
        RST = 1'b1;
        tick();
        expect_out("t2.rst", 1'b1, 1'b1, 1'b0);
        RST = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            if (e == 6) VDDIO_OK = 1'b0;
            if (e == 7) VDDIO_OK = 1'b1;
            tick();
            expect_out($sformatf("t2.e%0d", e), e < 17, e < 21, e >= 21);
        end

        // 3: supply drop in READY isolates three edges later and counts a brownout.
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
        chk("t3.bo_before", 32'(BROWNOUT_CNT), 32'(0));
`endif
        VDDIO_OK = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            expect_out($sformatf("t3.e%0d", e), e >= 3, e >= 3, e < 3);
        end
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
        chk("t3.bo_after", 32'(BROWNOUT_CNT), 32'(1));
`endif

        // 4: back to READY, then software isolation for 5 cycles; not a brownout.
        VDDIO_OK = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            expect_out($sformatf("t4a.e%0d", e), e < 11, e < 15, e >= 15);
        end
        SW_ISO_REQ = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            expect_out($sformatf("t4b.e%0d", e), 1'b1, 1'b1, 1'b0);
        end
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
        chk("t4.bo_sw", 32'(BROWNOUT_CNT), 32'(1));
`endif
        // ok_s is already high, so only OFF->DEBOUNCE + 8 + 4 edges remain.
        SW_ISO_REQ = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            expect_out($sformatf("t4c.e%0d", e), e < 9, e < 13, e >= 13);
        end

        // 5: reset pulse during HOLD_RST.
        SW_ISO_REQ = 1'b1;
        tick();
        expect_out("t5.iso_req", 1'b1, 1'b1, 1'b0);
        SW_ISO_REQ = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            expect_out($sformatf("t5a.e%0d", e), e < 9, 1'b1, 1'b0);
        end
        RST = 1'b1;
        tick();
        expect_out("t5.rst", 1'b1, 1'b1, 1'b0);
`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
        chk("t5.bo_clr", 32'(BROWNOUT_CNT), 32'(0));
`endif
        RST = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            expect_out($sformatf("t5b.e%0d", e), e < 11, e < 15, e >= 15);
        end

`ifdef IO_PWR_SEQ_BROWNOUT_CNT_EN
        // 6: 300 brownouts saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            VDDIO_OK = 1'b0;
            repeat (3) tick();
            VDDIO_OK = 1'b1;
            repeat (15) tick();
            if (i == 9)   chk("t6.bo10", 32'(BROWNOUT_CNT), 32'(10));
            if (i == 254) chk("t6.bo255", 32'(BROWNOUT_CNT), 32'(255));
        end
        chk("t6.bo_sat", 32'(BROWNOUT_CNT), 32'(255));
        expect_out("t6.end", 1'b0, 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
